// File: rtl/rv_pkg.sv
// Shared RV32 core definitions used by the pipeline hazard logic.
//   hz_state_t : hazard FSM states (idle, data-memory wait, deferred redirect)
//   HZ_NREGS   : number of architectural registers tracked by the scoreboard
package rv_pkg;

  localparam int unsigned HZ_NREGS = 32;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_REDIRECT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Busy-bit scoreboard for destinations of outstanding multi-cycle operations.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   issue_en          : gates new issues (low while the pipeline is frozen)
//   issue, issue_rd   : multi-cycle op leaves ID, marks its rd busy
//   done, done_rd     : multi-cycle result written back, clears its rd
//   rs1/rs2, use_rs*  : ID-stage sources to look up
//   busy_hit_c        : an in-use ID source is still busy (combinational)
module hz_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREGS = HZ_NREGS,
  parameter int unsigned RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_en,
  input  logic          issue,
  input  logic [RW-1:0] issue_rd,
  input  logic          done,
  input  logic [RW-1:0] done_rd,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use_rs1,
  input  logic          use_rs2,
  output logic          busy_hit_c
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             hit_rs1;
  logic             hit_rs2;

  // Clear first so a same-cycle issue to the same rd wins; x0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (done && (done_rd != '0)) busy_d[done_rd] = 1'b0;
    if (issue_en && issue && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // A write-back landing this cycle on the same rd bypasses the stall.
  always_comb begin
    hit_rs1 = use_rs1 && (rs1 != '0) && busy_q[rs1] && !(done && (done_rd == rs1));
    hit_rs2 = use_rs2 && (rs2 != '0) && busy_q[rs2] && !(done && (done_rd == rs2));
    busy_hit_c = hit_rs1 || hit_rs2;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage RV32 core: resolves hazards that
// forwarding cannot (load-use, outstanding multi-cycle results, data-memory
// wait states, taken redirects) by stalling and flushing pipeline registers.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_id_rs1/rs2, i_id_use_rs*   : ID-stage sources and their use flags
//   i_ex_rd, i_ex_mem_read       : EX destination and load flag
//   i_ex_branch_taken            : EX resolved a redirect
//   i_mc_issue(_rd), i_mc_done(_rd) : multi-cycle op issue / write-back
//   i_dmem_req, i_dmem_ready     : MEM-stage data request handshake
//   o_stall_*                    : hold PC, IF/ID, ID/EX, EX/MEM
//   o_flush_*                    : bubble into IF/ID, ID/EX
//   o_cnt_* (optional)           : saturating per-cause cycle counters
module hazard_unit
  import rv_pkg::*;
#(
  parameter int unsigned NREGS = HZ_NREGS,
  parameter int unsigned RW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [RW-1:0] i_id_rs1,
  input  logic [RW-1:0] i_id_rs2,
  input  logic          i_id_use_rs1,
  input  logic          i_id_use_rs2,
  input  logic [RW-1:0] i_ex_rd,
  input  logic          i_ex_mem_read,
  input  logic          i_ex_branch_taken,
  input  logic          i_mc_issue,
  input  logic [RW-1:0] i_mc_issue_rd,
  input  logic          i_mc_done,
  input  logic [RW-1:0] i_mc_done_rd,
  input  logic          i_dmem_req,
  input  logic          i_dmem_ready,
  output logic          o_stall_pc,
  output logic          o_stall_if_id,
  output logic          o_stall_id_ex,
  output logic          o_stall_ex_mem,
  output logic          o_flush_if_id,
  output logic          o_flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
 ,output logic [31:0]   o_cnt_mem_stall,
  output logic [31:0]   o_cnt_ldu_stall,
  output logic [31:0]   o_cnt_sb_stall,
  output logic [31:0]   o_cnt_flush
`endif
);

  hz_state_t state_q, state_d;
  logic      pend_q, pend_d;
  logic      freeze_c;
  logic      ldu_c;
  logic      sb_hit_c;
  logic      act_mem, act_flush, act_ldu, act_sb;

  assign freeze_c = i_dmem_req && !i_dmem_ready;

  assign ldu_c = i_ex_mem_read && (i_ex_rd != '0) &&
                 ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                  (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  // Issues are dropped while frozen since the issuing instruction stays in ID.
  hz_scoreboard #(
    .NREGS (NREGS),
    .RW    (RW)
  ) u_scoreboard (
    .clk        (i_clk),
    .rst        (i_rst),
    .issue_en   (!freeze_c),
    .issue      (i_mc_issue),
    .issue_rd   (i_mc_issue_rd),
    .done       (i_mc_done),
    .done_rd    (i_mc_done_rd),
    .rs1        (i_id_rs1),
    .rs2        (i_id_rs2),
    .use_rs1    (i_id_use_rs1),
    .use_rs2    (i_id_use_rs2),
    .busy_hit_c (sb_hit_c)
  );

  // State and pending-redirect registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HZ_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and priority-resolved action: freeze > redirect > load-use/scoreboard.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    act_mem   = 1'b0;
    act_flush = 1'b0;
    act_ldu   = 1'b0;
    act_sb    = 1'b0;
    if (freeze_c) begin
      act_mem = 1'b1;
      state_d = HZ_MEM_WAIT;
      if (i_ex_branch_taken) pend_d = 1'b1;
    end else if (state_q == HZ_REDIRECT) begin
      act_flush = 1'b1;
      pend_d    = 1'b0;
      state_d   = HZ_IDLE;
    end else begin
      // MEM_WAIT exit cycle behaves as normal operation for this cycle.
      if (state_q == HZ_MEM_WAIT) state_d = pend_q ? HZ_REDIRECT : HZ_IDLE;
      if (i_ex_branch_taken)  act_flush = 1'b1;
      else if (ldu_c)         act_ldu   = 1'b1;
      else if (sb_hit_c)      act_sb    = 1'b1;
    end
  end

  // Output decode; everything is held low during reset.
  always_comb begin
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    if (!i_rst) begin
      if (act_mem) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
      end else if (act_flush) begin
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if (act_ldu || act_sb) begin
        o_stall_pc    = 1'b1;
        o_stall_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating per-cause cycle counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_mem_stall <= '0;
      o_cnt_ldu_stall <= '0;
      o_cnt_sb_stall  <= '0;
      o_cnt_flush     <= '0;
    end else begin
      if (act_mem   && (o_cnt_mem_stall != '1)) o_cnt_mem_stall <= o_cnt_mem_stall + 32'd1;
      if (act_ldu   && (o_cnt_ldu_stall != '1)) o_cnt_ldu_stall <= o_cnt_ldu_stall + 32'd1;
      if (act_sb    && (o_cnt_sb_stall  != '1)) o_cnt_sb_stall  <= o_cnt_sb_stall + 32'd1;
      if (act_flush && (o_cnt_flush     != '1)) o_cnt_flush     <= o_cnt_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit. Outputs are compared as the
// vector {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex}.
module tb_hazard_unit;

  localparam int unsigned RW = 5;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LDU  = 6'b110001;
  localparam logic [5:0] FRZ  = 6'b111100;
  localparam logic [5:0] FL   = 6'b000011;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, mc_issue_rd, mc_done_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic          mc_issue, mc_done, dmem_req, dmem_ready;
  logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic          flush_if_id, flush_id_ex;
  logic [5:0]    outs;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_mem_stall, cnt_ldu_stall, cnt_sb_stall, cnt_flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex};

  hazard_unit dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_use_rs1      (id_use_rs1),
    .i_id_use_rs2      (id_use_rs2),
    .i_ex_rd           (ex_rd),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mc_issue        (mc_issue),
    .i_mc_issue_rd     (mc_issue_rd),
    .i_mc_done         (mc_done),
    .i_mc_done_rd      (mc_done_rd),
    .i_dmem_req        (dmem_req),
    .i_dmem_ready      (dmem_ready),
    .o_stall_pc        (stall_pc),
    .o_stall_if_id     (stall_if_id),
    .o_stall_id_ex     (stall_id_ex),
    .o_stall_ex_mem    (stall_ex_mem),
    .o_flush_if_id     (flush_if_id),
    .o_flush_id_ex     (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
   ,.o_cnt_mem_stall   (cnt_mem_stall),
    .o_cnt_ldu_stall   (cnt_ldu_stall),
    .o_cnt_sb_stall    (cnt_sb_stall),
    .o_cnt_flush       (cnt_flush)
`endif
  );

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mc_issue = 1'b0; mc_issue_rd = '0; mc_done = 1'b0; mc_done_rd = '0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Settle, compare current cycle's outputs, then advance to just past the next edge.
  task automatic step(input string tag, input logic [5:0] exp);
    #2;
    n_checks++;
    assert (outs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset holds outputs low even with a freeze and branch present.
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    step("reset_outputs", NONE);
    clear_inputs();
    rst = 1'b0;
    step("idle_after_reset", NONE);

    // Load-use on rs2.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    step("ldu_rs2", LDU);
    ex_mem_read = 1'b0;
    step("ldu_next", NONE);
    ex_mem_read = 1'b1; id_use_rs2 = 1'b0; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    step("ldu_unused_src", NONE);
    clear_inputs();

    // Freeze with a branch in cycle 2, then deferred redirect.
    dmem_req = 1'b1;
    step("freeze_c1", FRZ);
    ex_branch_taken = 1'b1;
    step("freeze_c2_branch", FRZ);
    ex_branch_taken = 1'b0;
    step("freeze_c3", FRZ);
    dmem_ready = 1'b1;
    step("freeze_ready", NONE);
    clear_inputs();
    step("deferred_redirect", FL);
    step("after_redirect", NONE);

    // Scoreboard stall until done, with done-bypass.
    mc_issue = 1'b1; mc_issue_rd = 5'd7;
    step("sb_issue", NONE);
    mc_issue = 1'b0; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    step("sb_c1", LDU);
    step("sb_c2", LDU);
    step("sb_c3", LDU);
    mc_done = 1'b1; mc_done_rd = 5'd7;
    step("sb_c4_done_bypass", NONE);
    mc_done = 1'b0;
    step("sb_cleared", NONE);
    clear_inputs();

    // Same-cycle issue and done on one rd: issue wins.
    mc_issue = 1'b1; mc_issue_rd = 5'd9; mc_done = 1'b1; mc_done_rd = 5'd9;
    step("sb_set_wins_cycle", NONE);
    clear_inputs();
    id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    step("sb_set_wins_stall", LDU);
    mc_done = 1'b1; mc_done_rd = 5'd9;
    step("sb_rd9_done", NONE);
    clear_inputs();

    // x0 never hazards.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    mc_issue = 1'b1; mc_issue_rd = 5'd0;
    step("x0_load", NONE);
    ex_mem_read = 1'b0; mc_issue = 1'b0;
    step("x0_scoreboard", NONE);
    clear_inputs();

    // Redirect beats load-use.
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    step("prio_branch_over_ldu", FL);
    clear_inputs();

    // Issue during freeze is discarded.
    dmem_req = 1'b1; mc_issue = 1'b1; mc_issue_rd = 5'd4;
    step("freeze_issue", FRZ);
    clear_inputs();
    id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    step("freeze_issue_dropped", NONE);
    clear_inputs();

    // Reset mid-freeze with pending redirect discards everything.
    mc_issue = 1'b1; mc_issue_rd = 5'd11;
    step("pre_reset_issue", NONE);
    clear_inputs();
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    step("pre_reset_freeze", FRZ);
    rst = 1'b1; ex_branch_taken = 1'b0;
    step("reset_mid_freeze", NONE);
    rst = 1'b0; dmem_ready = 1'b1;
    step("post_reset_ready", NONE);
    clear_inputs();
    id_rs1 = 5'd11; id_use_rs1 = 1'b1;
    step("post_reset_no_flush_sb_empty", NONE);
    step("post_reset_idle", NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage RV32 core. It is the counterpart of operand forwarding: it detects the hazards that forwarding cannot resolve and resolves them by stalling or flushing.
- Detected hazards: load-use, outstanding multi-cycle results, data-memory wait states and taken-branch redirects.
- Drives stall and flush enables for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Holds a register scoreboard and a small FSM for memory wait and deferred redirect.

Parameters:
- NREGS, 32, number of architectural registers; scoreboard width.
- RW, 5, register index width, equal to $clog2(NREGS).

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous active-high reset
- i_id_rs1  in  RW  ID-stage source 1
- i_id_rs2  in  RW  ID-stage source 2
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_ex_rd  in  RW  EX-stage destination
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_branch_taken  in  1  EX resolved a redirect (branch/jal/jalr)
- i_mc_issue  in  1  multi-cycle op leaves ID this cycle
- i_mc_issue_rd  in  RW  its destination
- i_mc_done  in  1  multi-cycle result written back this cycle
- i_mc_done_rd  in  RW  its destination
- i_dmem_req  in  1  MEM stage has an active data request
- i_dmem_ready  in  1  data memory accepts/completes request
- o_stall_pc  out  1  hold PC
- o_stall_if_id  out  1  hold IF/ID
- o_stall_id_ex  out  1  hold ID/EX
- o_stall_ex_mem  out  1  hold EX/MEM
- o_flush_if_id  out  1  insert bubble into IF/ID
- o_flush_id_ex  out  1  insert bubble into ID/EX

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset: FSM to IDLE, scoreboard cleared, pending-redirect flag cleared. While i_rst=1 all outputs are 0.
- Outputs are combinational from state and inputs; zero added latency.
- Register x0 never hazards; issue/done with rd=0 is ignored.
- FSM states (hz_state_t):
  - IDLE: normal operation.
  - MEM_WAIT: data memory stalled.
  - REDIRECT: deferred flush.
- Memory freeze:
  - Condition: i_dmem_req=1 && i_dmem_ready=0, in any state.
  - Response: o_stall_pc, o_stall_if_id, o_stall_id_ex and o_stall_ex_mem all 1; flushes 0; next state MEM_WAIT.
  - Exit: MEM_WAIT holds until i_dmem_ready=1, then goes to REDIRECT if the pending flag is set, else IDLE.
  - A ready=1 cycle itself produces no memory stall.
- Taken branch during freeze:
  - i_ex_branch_taken=1 while frozen sets the pending flag instead of flushing.
  - REDIRECT lasts exactly one cycle: o_flush_if_id=1, o_flush_id_ex=1, flag cleared, back to IDLE.
- Taken branch in IDLE: o_flush_if_id=1 and o_flush_id_ex=1 in the same cycle, no stall.
- Load-use:
  - Condition: i_ex_mem_read && i_ex_rd!=0 && ((i_id_use_rs1 && rs1==ex_rd) || (i_id_use_rs2 && rs2==ex_rd)).
  - Response: o_stall_pc=1, o_stall_if_id=1, o_flush_id_ex=1 for one cycle. Forwarding covers the following cycle.
- Scoreboard:
  - Set: i_mc_issue sets bit[i_mc_issue_rd].
  - Clear: i_mc_done clears bit[i_mc_done_rd].
  - Same-cycle set and clear of the same rd: set wins (new issue).
  - Stall: if an ID source in use has its busy bit set, apply the load-use response, repeated each cycle until the bit clears.
  - Done-bypass: a done on the same rd this cycle does not stall.
- Priority: memory freeze > redirect (IDLE or REDIRECT) > scoreboard/load-use.
  - A redirect suppresses load-use stalls, since the ID instruction is being flushed.
- Scoreboard updates are suppressed while the memory freeze is active, except i_mc_done.
- Reset asserted mid-freeze or mid-redirect: discard everything, return to IDLE next cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds 32-bit counters o_cnt_mem_stall, o_cnt_ldu_stall, o_cnt_sb_stall and o_cnt_flush.
  - Each counter increments once per cycle its cause is the active (highest-priority) action.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- rv_pkg gains:
  - hz_state_t enum {HZ_IDLE, HZ_MEM_WAIT, HZ_REDIRECT}.
  - Constant HZ_NREGS = 32.
- One natural sub-module: hz_scoreboard, containing the busy-bit array with set/clear/lookup for two sources plus done-bypass. The FSM and priority logic stay in hazard_unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, use_rs2=1 -> one cycle with stall_pc=stall_if_id=flush_id_ex=1; next cycle (ex_mem_read=0) all outputs 0.
- Memory freeze with branch: dmem_req=1, ready=0 for 3 cycles, branch_taken=1 in cycle 2 -> all four stalls 1 for 3 cycles. On ready, the following cycle flush_if_id=flush_id_ex=1 for exactly one cycle.
- Scoreboard: mc_issue rd=7; ID reads rs1=7 for 4 cycles; mc_done rd=7 in cycle 4 -> stalls in cycles 1-3, none in cycle 4.
- x0 immunity: load with ex_rd=0 and id_rs1=0, plus mc_issue rd=0 -> no stall ever.
- Priority: branch_taken=1 together with a load-use match -> flushes only, stall_pc=0.
- Reset mid-freeze: i_rst=1 during MEM_WAIT with the pending flag set -> outputs 0; after reset, ready=1 produces no flush and the scoreboard is empty.
